// File: rtl/compressor_result_unloader_pkg.sv
// Shared definitions for the compressor result unloader and its bench.
//   state_t    : serializer FSM states
//   DEF_WIDTH  : default number of compressor result columns
//   DEF_POLY   : default MISR feedback taps (x^22 + x + 1)
//   misr_next  : one MISR step; operands are carried in a MISR_MAX_W-bit
//                container and masked to the active register width
package cmp_tb_pkg;

  typedef enum logic {IDLE, SHIFT} state_t;

  localparam int unsigned DEF_WIDTH  = 22;
  localparam logic [DEF_WIDTH-1:0] DEF_POLY = 22'h000003;
  localparam int unsigned MISR_MAX_W = 64;

  function automatic logic [MISR_MAX_W-1:0] misr_next(
    input logic [MISR_MAX_W-1:0] sig,
    input logic [MISR_MAX_W-1:0] data,
    input logic [MISR_MAX_W-1:0] poly,
    input int unsigned           width
  );
    logic [MISR_MAX_W-1:0] mask;
    logic [MISR_MAX_W-1:0] nxt;
    mask = (width >= MISR_MAX_W) ? '1
                                 : ((MISR_MAX_W'(1) << width) - MISR_MAX_W'(1));
    nxt  = (sig << 1) & mask;
    if (sig[6'(width - 1)]) nxt = nxt ^ poly;
    return (nxt ^ data) & mask;
  endfunction

endpackage

// File: rtl/compressor_result_unloader_misr.sv
// Multiple-input signature register with clear and enable.
//   clk, rst_n : clock, synchronous active-low reset
//   i_clr      : zero the signature (folds i_data into zero when i_en is high)
//   i_en       : fold i_data into the signature
//   i_data     : WIDTH-bit word to compact
//   o_sig      : current signature
module misr_reg
  import cmp_tb_pkg::*;
#(
  parameter int unsigned          WIDTH = DEF_WIDTH,
  parameter logic [WIDTH-1:0]     POLY  = WIDTH'(DEF_POLY)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_sig
);

  logic [WIDTH-1:0] r_sig;
  logic [WIDTH-1:0] w_base;
  logic [WIDTH-1:0] w_next;

  // A clear coinciding with an update compacts into an all-zero register.
  always_comb begin
    w_base = i_clr ? '0 : r_sig;
    w_next = WIDTH'(misr_next(MISR_MAX_W'(w_base), MISR_MAX_W'(i_data),
                              MISR_MAX_W'(POLY), WIDTH));
  end

  always_ff @(posedge clk) begin
    if (!rst_n)     r_sig <= '0;
    else if (i_en)  r_sig <= w_next;
    else if (i_clr) r_sig <= '0;
  end

  assign o_sig = r_sig;

endmodule

// File: rtl/compressor_result_unloader.sv
// Captures the compressor's WIDTH-bit result and streams it out LSB first
// over a valid/ready handshake, compacting each accepted result in a MISR.
//   clk, rst_n             : clock, synchronous active-low reset
//   dst, capture           : result word and one-cycle capture request
//   sout, sout_valid,
//   sout_last, sout_ready  : serial stream, last flags bit WIDTH-1
//   busy                   : a capture this cycle would be dropped
//   overrun                : sticky, a capture was dropped
//   sig, sig_clr           : MISR signature and its clear
//   cap_count              : accepted captures, saturating
module compressor_result_unloader
  import cmp_tb_pkg::*;
#(
  parameter int unsigned      WIDTH = DEF_WIDTH,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(DEF_POLY),
  parameter int unsigned      CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] dst,
  input  logic             capture,
  output logic             sout,
  output logic             sout_valid,
  output logic             sout_last,
  input  logic             sout_ready,
  output logic             busy,
  output logic             overrun,
  output logic [WIDTH-1:0] sig,
  input  logic             sig_clr,
  output logic [CNT_W-1:0] cap_count
);

  localparam int unsigned     BW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0]   LAST_IDX = BW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_shadow;
  logic [BW-1:0]    r_bit_cnt;
  logic             r_overrun;
  logic [CNT_W-1:0] r_cap_count;

  logic w_shift;
  logic w_last;
  logic w_beat;
  logic w_busy;
  logic w_accept;

  always_comb begin
    w_shift  = (r_state == SHIFT);
    w_last   = w_shift && (r_bit_cnt == LAST_IDX);
    w_beat   = w_shift && sout_ready;
    // The final beat frees the shadow in the same cycle, so a capture there
    // is taken and the next result follows with no bubble.
    w_busy   = w_shift && !(w_last && sout_ready);
    w_accept = capture && !w_busy;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = SHIFT;
      SHIFT:   if (w_beat && w_last && !w_accept) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Shadow register and beat counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_shadow  <= '0;
      r_bit_cnt <= '0;
    end else if (w_accept) begin
      r_shadow  <= dst;
      r_bit_cnt <= '0;
    end else if (w_beat) begin
      r_shadow  <= r_shadow >> 1;
      r_bit_cnt <= r_bit_cnt + BW'(1);
    end
  end

  // Overrun flag and saturating capture counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_overrun   <= 1'b0;
      r_cap_count <= '0;
    end else begin
      if (capture && w_busy) r_overrun <= 1'b1;
      if (w_accept && (r_cap_count != '1)) r_cap_count <= r_cap_count + CNT_W'(1);
    end
  end

  misr_reg #(
    .WIDTH (WIDTH),
    .POLY  (POLY)
  ) u_misr (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (sig_clr),
    .i_en   (w_accept),
    .i_data (dst),
    .o_sig  (sig)
  );

  // Output decode
  always_comb begin
    sout       = w_shift && r_shadow[0];
    sout_valid = w_shift;
    sout_last  = w_last;
    busy       = w_busy;
    overrun    = r_overrun;
    cap_count  = r_cap_count;
  end

endmodule

// File: tb/tb_compressor_result_unloader.sv
module tb_compressor_result_unloader;
  import cmp_tb_pkg::*;

  localparam int unsigned W = 22;

  logic          clk;
  logic          rst_n;
  logic [W-1:0]  dst;
  logic          capture;
  logic          sout;
  logic          sout_valid;
  logic          sout_last;
  logic          sout_ready;
  logic          busy;
  logic          overrun;
  logic [W-1:0]  sig;
  logic          sig_clr;
  logic [15:0]   cap_count;

  compressor_result_unloader #(
    .WIDTH (W),
    .POLY  (22'h000003),
    .CNT_W (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .dst        (dst),
    .capture    (capture),
    .sout       (sout),
    .sout_valid (sout_valid),
    .sout_last  (sout_last),
    .sout_ready (sout_ready),
    .busy       (busy),
    .overrun    (overrun),
    .sig        (sig),
    .sig_clr    (sig_clr),
    .cap_count  (cap_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit           m_shift;
  int unsigned  m_cnt;
  logic [W-1:0] m_sig;
  logic         m_ovr;
  logic [15:0]  m_cap;
  bit           q[$];
  int           n_beats;
  int           n_lasts;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_shift = 0; m_cnt = 0; m_sig = '0; m_ovr = 0; m_cap = '0;
    q.delete();
  endtask

  // Compare outputs against the model, advance the model with the current
  // inputs, then move to the next falling edge.
  task automatic tick();
    bit beat, last, accept;
    #1;
    check_eq("sout_valid", sout_valid, m_shift);
    check_eq("busy", busy, m_shift && !(m_cnt == W - 1 && sout_ready));
    check_eq("sig", sig, m_sig);
    check_eq("cap_count", cap_count, m_cap);
    check_eq("overrun", overrun, m_ovr);
    if (m_shift) begin
      check_eq("q_nonempty", q.size() != 0, 1);
      if (q.size() != 0) check_eq("sout", sout, q[0]);
      check_eq("sout_last", sout_last, m_cnt == W - 1);
    end else begin
      check_eq("sout_idle", sout, 0);
      check_eq("sout_last_idle", sout_last, 0);
    end
    if (!rst_n) begin
      model_reset();
    end else begin
      beat   = m_shift && sout_ready;
      last   = (m_cnt == W - 1);
      accept = capture && (!m_shift || (last && sout_ready));
      if (beat) begin
        if (q.size() != 0) void'(q.pop_front());
        n_beats++;
        if (last) n_lasts++;
      end
      if (capture && !accept) m_ovr = 1;
      if (accept) begin
        m_sig = W'(misr_next(64'(sig_clr ? '0 : m_sig), 64'(dst), 64'(22'h000003), W));
        if (m_cap != 16'hFFFF) m_cap = m_cap + 16'd1;
        for (int unsigned i = 0; i < W; i++) q.push_back(dst[i]);
        m_shift = 1;
        m_cnt   = 0;
      end else begin
        if (sig_clr) m_sig = '0;
        if (beat) begin
          if (last) m_shift = 0;
          else      m_cnt++;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cap(input logic [W-1:0] d, input logic clr);
    dst = d; capture = 1'b1; sig_clr = clr;
    tick();
    capture = 1'b0; sig_clr = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && m_shift; i++) tick();
    check_eq("drain_done", sout_valid, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  logic [W-1:0] z;

  initial begin
    rst_n = 1'b0; dst = '0; capture = 1'b0; sout_ready = 1'b1; sig_clr = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    tick();
    rst_n = 1'b1;
    check_eq("rst_sig", sig, 0);
    check_eq("rst_cap", cap_count, 0);

    // Alternating pattern, full stream
    n_beats = 0; n_lasts = 0;
    cap(22'h2AAAAA, 1'b0);
    drain();
    check_eq("alt_beats", n_beats, 22);
    check_eq("alt_lasts", n_lasts, 1);
    check_eq("alt_capcnt", cap_count, 1);

    // Signature sequence from reset
    do_reset();
    cap(22'h000001, 1'b0);
    check_eq("sig_a", sig, 22'h000001);
    drain();
    cap(22'h000000, 1'b0);
    check_eq("sig_b", sig, 22'h000002);
    drain();

    // Feedback tap: preload top bit, fold in zero
    cap(22'h200000, 1'b1);
    check_eq("sig_pre", sig, 22'h200000);
    drain();
    cap(22'h000000, 1'b0);
    check_eq("sig_fb", sig, 22'h000003);
    drain();

    // Backpressure mid-stream
    n_beats = 0;
    cap(22'h15C3A9, 1'b0);
    repeat (6) tick();
    sout_ready = 1'b0;
    repeat (5) tick();
    sout_ready = 1'b1;
    drain();
    check_eq("bp_beats", n_beats, 22);

    // Capture mid-stream is dropped; capture on final beat is taken
    cap(22'h0F0F0F, 1'b0);
    repeat (9) tick();
    cap(22'h3FFFFF, 1'b0);
    check_eq("ovr_set", overrun, 1);
    for (int i = 0; i < 40 && m_cnt != W - 1; i++) tick();
    check_eq("at_last", sout_last, 1);
    z = 22'h12345B;
    cap(z, 1'b0);
    check_eq("b2b_valid", sout_valid, 1);
    check_eq("b2b_bit0", sout, z[0]);
    drain();

    // Reset aborts a transfer
    cap(22'h3ABCDE, 1'b0);
    repeat (5) tick();
    do_reset();
    check_eq("abort_valid", sout_valid, 0);
    check_eq("abort_ovr", overrun, 0);
    check_eq("abort_sig", sig, 0);
    check_eq("abort_cap", cap_count, 0);

    // Clear coinciding with capture
    cap(22'h000001, 1'b0);
    drain();
    cap(22'h00000F, 1'b1);
    check_eq("clr_cap", sig, 22'h00000F);
    drain();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      sout_ready = ($urandom_range(0, 3) != 0);
      capture    = ($urandom_range(0, 7) == 0);
      sig_clr    = ($urandom_range(0, 31) == 0);
      dst        = W'($urandom);
      tick();
    end
    capture = 1'b0; sig_clr = 1'b0; sout_ready = 1'b1;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
